// File: rtl/serial_subtractor_switch.sv
// Bit-serial unsigned subtractor D = A - B, LSB first, one bit per clock.
// The per-bit cell is a full subtractor built from two half subtractors.

module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);
   assign d    = a ^ b;
   assign bout = ~a & b;
endmodule

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1, b1, b2;

   half_subtractor u_hs1 (.a(a),  .b(b),   .d(d1), .bout(b1));
   half_subtractor u_hs2 (.a(d1), .b(bin), .d(d),  .bout(b2));

   assign bout = b1 | b2;
endmodule

module serial_subtractor_switch #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] D,
   output logic             BOUT
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state, next_state;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             borrow;
   logic [CNT_W-1:0] count;
   logic             cell_d, cell_bout;
   logic             last_bit;

   full_subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last_bit = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (START) next_state = SHIFT;
         SHIFT:   if (last_bit) next_state = FINISH;
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state == SHIFT);
      DONE = (state == FINISH);
   end

   // D/BOUT are written on the edge that enters FINISH, so they are already
   // valid during the DONE cycle and never move at any other time.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         count  <= '0;
         D      <= '0;
         BOUT   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (START) begin
                  a_sr   <= A;
                  b_sr   <= B;
                  borrow <= 1'b0;
                  count  <= '0;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {cell_d, res_sr[WIDTH-1:1]};
               borrow <= cell_bout;
               count  <= count + CNT_W'(1);
               if (last_bit) begin
                  D    <= {cell_d, res_sr[WIDTH-1:1]};
                  BOUT <= cell_bout;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor_switch.sv
// Randomized self-checking bench for serial_subtractor_switch against the
// arithmetic model {BOUT,D} = {A<B, A-B mod 2^W}.

module tb_serial_subtractor_switch;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         START;
   logic [W-1:0] A, B;
   logic         BUSY, DONE;
   logic [W-1:0] D;
   logic         BOUT;

   int unsigned  n_checks = 0;
   int unsigned  n_pass   = 0;
   int unsigned  cyc_cnt  = 0;
   int unsigned  done_stamp;
   logic [W-1:0] last_d;
   logic         last_b;

   serial_subtractor_switch #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .START (START),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .D     (D),
      .BOUT  (BOUT)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One operation starting from IDLE. disturb pulses START and scrambles A/B
   // mid-operation; hold leaves START asserted on return.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input bit disturb, input string tag);
      logic [W-1:0] exp_d;
      logic         exp_b;
      int unsigned  cyc, busy_n;
      bit           stable;
      exp_d  = a - b;
      exp_b  = (a < b);
      A      = a;
      B      = b;
      START  = 1'b1;
      @(posedge clk); #1;
      if (!hold) START = 1'b0;
      cyc    = 1;
      busy_n = 0;
      stable = 1'b1;
      while (!DONE && cyc < 40) begin
         if (BUSY) busy_n++;
         if (D !== last_d || BOUT !== last_b) stable = 1'b0;
         if (disturb && cyc == 3) begin
            START = 1'b1;
            A     = ~a;
            B     = a ^ b ^ W'($urandom);
         end
         if (disturb && cyc == 5) START = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
      done_stamp = cyc_cnt;
      check({tag, " latency"}, cyc, W + 1);
      check({tag, " busy_cycles"}, busy_n, W);
      check({tag, " result_stable"}, {31'd0, stable}, 32'd1);
      check({tag, " D"}, {24'd0, D}, {24'd0, exp_d});
      check({tag, " BOUT"}, {31'd0, BOUT}, {31'd0, exp_b});
      last_d = exp_d;
      last_b = exp_b;
      @(posedge clk); #1;
      check({tag, " done_pulse"}, {31'd0, DONE}, 32'd0);
   endtask

   initial begin
      int unsigned  prev_stamp, saw_done;
      logic [W-1:0] ra, rb;
      reset  = 1'b1;
      START  = 1'b0;
      A      = '0;
      B      = '0;
      last_d = '0;
      last_b = 1'b0;
      #12;
      check("rst BUSY", {31'd0, BUSY}, 32'd0);
      check("rst DONE", {31'd0, DONE}, 32'd0);
      check("rst D",    {24'd0, D},    32'd0);
      check("rst BOUT", {31'd0, BOUT}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(8'h05, 8'h03, 0, 0, "t1");
      run_op(8'h03, 8'h05, 0, 0, "t2a");
      run_op(8'h00, 8'h01, 0, 0, "t2b");
      run_op(8'hFF, 8'hFF, 0, 0, "t3a");
      run_op(8'h00, 8'h00, 0, 0, "t3b");
      run_op(8'h80, 8'h7F, 0, 0, "t3c");
      run_op(8'h3C, 8'hA5, 0, 1, "t4");

      // Reset in cycle 4 of SHIFT must clear outputs at once and kill DONE.
      A = 8'h9A; B = 8'h17; START = 1'b1;
      @(posedge clk); #1;
      START = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t5 BUSY", {31'd0, BUSY}, 32'd0);
      check("t5 D",    {24'd0, D},    32'd0);
      check("t5 BOUT", {31'd0, BOUT}, 32'd0);
      @(posedge clk); #1;
      reset    = 1'b0;
      saw_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (DONE) saw_done++;
      end
      check("t5 no_done", saw_done, 0);
      last_d = '0;
      last_b = 1'b0;
      run_op(8'h41, 8'h42, 0, 0, "t5 next");

      // START held high: back-to-back operations, DONE every W+2 cycles.
      run_op(8'h10, 8'h20, 1, 0, "t6a");
      prev_stamp = done_stamp;
      run_op(8'hC8, 8'h64, 1, 0, "t6b");
      check("t6 interval1", done_stamp - prev_stamp, W + 2);
      prev_stamp = done_stamp;
      run_op(8'h01, 8'hFE, 0, 0, "t6c");
      check("t6 interval2", done_stamp - prev_stamp, W + 2);

      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 50 == 0) rb = ra;
         run_op(ra, rb, 0, 0, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
